// File: rtl/finder_scan.sv
// finder_scan: scans a binary frame row-wise then column-wise, run-length encodes each
// line and marks QR finder (1:1:3:1:1) centres in per-column and per-row masks.
// Ports:
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   start_in           frame-ready pulse, accepted only when idle
//   pixel_in           BRAM read data (1=white), valid two cycles after its address
//   address_out        BRAM read address row*WIDTH+col
//   horz_patterns_out  bit c set: a finder centre lies in column c
//   vert_patterns_out  bit r set: a finder centre lies in row r
//   busy_out           high from start accept through the done cycle
//   start_cross_out    one-cycle pulse when masks become valid
//   match_count_out    ratio matches this frame, saturating at 0xFFFF
module finder_scan #(
  parameter int WIDTH = 480,
  parameter int HEIGHT = 480
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              pixel_in,
  output logic [19:0]       address_out,
  output logic [WIDTH-1:0]  horz_patterns_out,
  output logic [HEIGHT-1:0] vert_patterns_out,
  output logic              busy_out,
  output logic              start_cross_out,
  output logic [15:0]       match_count_out
);
  localparam logic [11:0] W = 12'(WIDTH);
  localparam logic [11:0] H = 12'(HEIGHT);
  localparam int HB = $clog2(WIDTH);
  localparam int VB = $clog2(HEIGHT);
  typedef enum logic [2:0] {IDLE, SCAN_H, DRAIN_H, SCAN_V, DRAIN_V, DONE} state_t;
  state_t state;
  logic [11:0] fast, slow, len_f, len_s, t_pos0, t_pos1, cen_a, cen_b;
  logic [1:0] t_vld, t_vert, t_sol, t_eol;
  logic i_vld, i_sol, i_eol, last_f;
  logic cur_col, p_ch, p_eol, m_a, m_b;
  logic [8:0] cur_len, n_len;
  logic [2:0] done_cnt, d_a, d_b;
  logic [4:0][8:0] rl, l_a, l_b;
  logic [4:0] rc, c_a, c_b;
  logic [16:0] cnt_n;
  // Index 0 is the newest run (r5), index 4 the oldest (r1); colour 0 = black.
  function automatic logic fmatch(input logic [4:0][8:0] l, input logic [4:0] c);
    logic [15:0] t, p;
    t = 16'(l[0]) + 16'(l[1]) + 16'(l[2]) + 16'(l[3]) + 16'(l[4]);
    fmatch = c == 5'b01010;
    for (int k = 0; k < 5; k++) begin
      p = 16'(l[k]) * 16'd14;
      fmatch &= k == 2 ? (p >= 16'd5 * t && p <= 16'd7 * t) : (p >= t && p <= 16'd3 * t);
    end
  endfunction
  always_comb begin
    len_f = state == SCAN_V ? H : W;
    len_s = state == SCAN_V ? W : H;
    i_vld = state == SCAN_H || state == SCAN_V;
    last_f = fast == len_f - 12'd1;
    i_sol = i_vld && fast == 12'd0;
    i_eol = i_vld && last_f;
    // A colour change closes the old run; an eol pixel then closes the run it belongs to.
    p_ch = t_vld[1] && !t_sol[1] && pixel_in != cur_col;
    p_eol = t_vld[1] && t_eol[1];
    l_a = p_ch ? {rl[3:0], cur_len} : rl;
    c_a = p_ch ? {rc[3:0], cur_col} : rc;
    d_a = t_sol[1] ? 3'd0 : (p_ch && done_cnt != 3'd5) ? done_cnt + 3'd1 : done_cnt;
    m_a = p_ch && d_a == 3'd5 && fmatch(l_a, c_a);
    cen_a = t_pos1 - 12'(l_a[0]) - 12'(l_a[1]) - 12'(l_a[2]) + 12'(l_a[2] >> 1);
    n_len = (t_sol[1] || p_ch) ? 9'd1 : cur_len == 9'd511 ? cur_len : cur_len + 9'd1;
    l_b = p_eol ? {l_a[3:0], n_len} : l_a;
    c_b = p_eol ? {c_a[3:0], pixel_in} : c_a;
    d_b = (p_eol && d_a != 3'd5) ? d_a + 3'd1 : d_a;
    m_b = p_eol && d_b == 3'd5 && fmatch(l_b, c_b);
    cen_b = t_pos1 + 12'd1 - 12'(l_b[0]) - 12'(l_b[1]) - 12'(l_b[2]) + 12'(l_b[2] >> 1);
    cnt_n = {1'b0, match_count_out} + 17'(m_a) + 17'(m_b);
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      fast <= '0;
      slow <= '0;
      address_out <= '0;
      horz_patterns_out <= '0;
      vert_patterns_out <= '0;
      busy_out <= 1'b0;
      start_cross_out <= 1'b0;
      match_count_out <= '0;
      t_vld <= '0;
      t_vert <= '0;
      t_sol <= '0;
      t_eol <= '0;
      t_pos0 <= '0;
      t_pos1 <= '0;
      cur_col <= 1'b0;
      cur_len <= '0;
      done_cnt <= '0;
      rl <= '0;
      rc <= '0;
    end else begin
      t_vld <= {t_vld[0], i_vld};
      t_vert <= {t_vert[0], state == SCAN_V};
      t_sol <= {t_sol[0], i_sol};
      t_eol <= {t_eol[0], i_eol};
      t_pos0 <= fast;
      t_pos1 <= t_pos0;
      start_cross_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          state <= SCAN_H;
          busy_out <= 1'b1;
          horz_patterns_out <= '0;
          vert_patterns_out <= '0;
          match_count_out <= '0;
          fast <= '0;
          slow <= '0;
          address_out <= '0;
        end
        SCAN_H, SCAN_V: begin
          fast <= last_f ? 12'd0 : fast + 12'd1;
          slow <= last_f ? slow + 12'd1 : slow;
          // Column-major: step down a row, or wrap to the top of the next column.
          address_out <= state == SCAN_H ? address_out + 20'd1 :
                         last_f ? 20'(slow) + 20'd1 : address_out + 20'(WIDTH);
          if (last_f && slow == len_s - 12'd1) begin
            state <= state == SCAN_H ? DRAIN_H : DRAIN_V;
            slow <= '0;
          end
        end
        DRAIN_H, DRAIN_V: begin
          fast <= fast + 12'd1;
          if (fast[0]) begin
            state <= state == DRAIN_H ? SCAN_V : DONE;
            start_cross_out <= state == DRAIN_V;
            fast <= '0;
            address_out <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
      if (t_vld[1]) begin
        cur_col <= pixel_in;
        cur_len <= n_len;
        done_cnt <= d_b;
        rl <= l_b;
        rc <= c_b;
        match_count_out <= cnt_n[16] ? 16'hFFFF : cnt_n[15:0];
        if (m_a && !t_vert[1] && cen_a < W) horz_patterns_out[cen_a[HB-1:0]] <= 1'b1;
        if (m_b && !t_vert[1] && cen_b < W) horz_patterns_out[cen_b[HB-1:0]] <= 1'b1;
        if (m_a && t_vert[1] && cen_a < H) vert_patterns_out[cen_a[VB-1:0]] <= 1'b1;
        if (m_b && t_vert[1] && cen_b < H) vert_patterns_out[cen_b[VB-1:0]] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_finder_scan.sv
// tb_finder_scan: directed frames for finder_scan with a line-level run-length model.
module tb_finder_scan;
  localparam int N = 32;
  logic clk = 0, rst_n = 0, start = 0, pixel, d1, d2;
  logic [19:0] address;
  logic [N-1:0] horz, vert, exp_h, exp_v;
  logic busy, sc;
  logic [15:0] count;
  logic [N-1:0] img [N];
  int exp_n = 0, e0 = -1, cyc = 0, nchk = 0, nerr = 0;
  finder_scan #(.WIDTH(N), .HEIGHT(N)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .pixel_in(pixel),
    .address_out(address), .horz_patterns_out(horz), .vert_patterns_out(vert),
    .busy_out(busy), .start_cross_out(sc), .match_count_out(count));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1 <= img[address[9:5]][address[4:0]];
    d2 <= d1;
  end
  assign pixel = d2;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  // Per line: build the run list, then test every window of five consecutive runs.
  task automatic model();
    int rl[N], rc[N], re[N];
    int nr, t, c, px;
    bit ok;
    exp_h = '0;
    exp_v = '0;
    exp_n = 0;
    for (int d = 0; d < 2; d++)
      for (int ln = 0; ln < N; ln++) begin
        nr = 0;
        for (int p = 0; p < N; p++) begin
          px = d == 0 ? int'(img[ln][p]) : int'(img[p][ln]);
          if (nr > 0 && px == rc[nr-1]) begin
            rl[nr-1]++;
            re[nr-1] = p + 1;
          end else begin
            rl[nr] = 1;
            rc[nr] = px;
            re[nr] = p + 1;
            nr++;
          end
        end
        for (int i = 4; i < nr; i++) begin
          t = rl[i] + rl[i-1] + rl[i-2] + rl[i-3] + rl[i-4];
          ok = rc[i] == 0 && rc[i-1] == 1 && rc[i-2] == 0 && rc[i-3] == 1 && rc[i-4] == 0;
          for (int k = 0; k < 5; k++)
            ok &= k == 2 ? (14 * rl[i-k] >= 5 * t && 14 * rl[i-k] <= 7 * t)
                         : (14 * rl[i-k] >= t && 14 * rl[i-k] <= 3 * t);
          if (ok) begin
            c = re[i] - rl[i] - rl[i-1] - rl[i-2] + rl[i-2] / 2;
            if (d == 0) exp_h[c] = 1'b1;
            else exp_v[c] = 1'b1;
            exp_n++;
          end
        end
      end
  endtask
  task automatic white();
    for (int r = 0; r < N; r++) img[r] = '1;
  endtask
  task automatic finder(input int x0, input int y0);
    int m;
    for (int dy = 0; dy < 14; dy++)
      for (int dx = 0; dx < 14; dx++) begin
        m = dx;
        if (dy < m) m = dy;
        if (13 - dx < m) m = 13 - dx;
        if (13 - dy < m) m = 13 - dy;
        img[y0+dy][x0+dx] = (m / 2 == 1);
      end
  endtask
  task automatic start_frame();
    @(posedge clk);
    #2;
    model();
    start = 1;
    e0 = cyc + 1;
    @(posedge clk);
    #2;
    start = 0;
    chk("clr_horz", 32'(horz), 0);
    chk("clr_vert", 32'(vert), 0);
    chk("clr_count", 32'(count), 0);
    chk("start_busy", 32'(busy), 1);
  endtask
  task automatic run_frame();
    start_frame();
    repeat (2056) @(posedge clk);
  endtask
  always @(negedge clk)
    if (e0 < 0) begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_start_cross", 32'(sc), 0);
      chk("idle_horz", 32'(horz), 0);
      chk("idle_vert", 32'(vert), 0);
      chk("idle_count", 32'(count), 0);
    end else begin
      chk("busy", 32'(busy), 32'(cyc >= e0 && cyc <= e0 + 2052));
      chk("start_cross", 32'(sc), 32'(cyc == e0 + 2052));
      if (cyc >= e0 + 2052) begin
        chk("horz", 32'(horz), 32'(exp_h));
        chk("vert", 32'(vert), 32'(exp_v));
        chk("count", 32'(count), 32'(exp_n));
      end
    end
  initial begin
    white();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    run_frame();
    chk("m1_h", 32'(exp_h), 0);
    chk("m1_n", 32'(exp_n), 0);
    finder(4, 4);
    run_frame();
    chk("m2_h", 32'(exp_h), 32'h0000_0800);
    chk("m2_v", 32'(exp_v), 32'h0000_0800);
    chk("m2_n", 32'(exp_n), 12);
    white();
    img[5][4:3] = 2'b00;
    img[5][8:7] = 2'b00;
    img[5][12:11] = 2'b00;
    run_frame();
    chk("m3_h", 32'(exp_h), 0);
    chk("m3_n", 32'(exp_n), 0);
    white();
    finder(18, 4);
    run_frame();
    chk("m4_h", 32'(exp_h), 32'h0200_0000);
    chk("m4_v", 32'(exp_v), 32'h0000_0800);
    start_frame();
    repeat (1500) @(posedge clk);
    #2;
    start = 1;
    @(posedge clk);
    #2;
    start = 0;
    repeat (600) @(posedge clk);
    start_frame();
    repeat (300) @(posedge clk);
    #2;
    rst_n = 0;
    e0 = -1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_horz", 32'(horz), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_start_cross", 32'(sc), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    run_frame();
    white();
    finder(4, 4);
    run_frame();
    white();
    finder(10, 12);
    run_frame();
    chk("m6_h", 32'(exp_h), 32'h0002_0000);
    chk("m6_v", 32'(exp_v), 32'h0008_0000);
    chk("m6_n", 32'(exp_n), 12);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
